clock_12h_set_ctrl: RTL and testbench
=====================================

Name: clock_12h_set_ctrl

Overview:
- Time-setting controller that sequences the 12-hour BCD clock counter (hh/mm/ss/pm).
- Gates the counter's 1 Hz enable and freezes time while the user edits it.
- Edits shadow copies of hour, minute and second from two pre-debounced button pulses.
- Issues a single-cycle parallel load to the counter on commit; an inactivity timeout aborts without loading.

Parameters:
- TIMEOUT_S, 30, number of tick_1hz pulses without a button press, in any SET state, before aborting to RUN (legal range 1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse, once per second.
- btn_mode  in  1  one-cycle pulse, debounced; advances the mode.
- btn_inc  in  1  one-cycle pulse, debounced; increments the field being edited.
- cur_hh  in  8  live BCD hours from the counter, {tens, ones}, 01..12.
- cur_mm  in  8  live BCD minutes, 00..59.
- cur_ss  in  8  live BCD seconds, 00..59.
- cur_pm  in  1  live pm flag.
- clk_ena  out  1  enable to the counter (its ena input).
- load  out  1  one-cycle parallel-load strobe to the counter.
- load_hh  out  8  BCD hours to load; also the displayed edit value.
- load_mm  out  8  BCD minutes to load.
- load_ss  out  8  BCD seconds to load.
- load_pm  out  1  pm value to load.
- mode  out  2  0=RUN, 1=SET_HH, 2=SET_MM, 3=SET_SS (COMMIT reports 0).
- blink  out  1  toggles on each tick_1hz while in a SET state; 0 in RUN.

Behaviour:
- States: RUN, SET_HH, SET_MM, SET_SS, COMMIT. Registered; encoding is free.
- Reset (reset=0, asynchronous):
  - state=RUN, load=0, blink=0, timeout counter=0.
  - Shadows: hh=8'h12, mm=8'h00, ss=8'h00, pm=0.
  - clk_ena is 0 for the duration of reset.
- clk_ena = tick_1hz AND state==RUN AND NOT btn_mode (combinational). A tick arriving in the same cycle as btn_mode in RUN is dropped.
- RUN + btn_mode:
  - Shadows capture cur_hh/mm/ss/pm on that edge.
  - Next state SET_HH; timeout counter clears.
- SET_HH + btn_inc: hour advances 01→…→09→10→11→12→01. The 11→12 step toggles shadow pm.
- SET_MM + btn_inc: minute 00..59, +1 BCD, 59→00. No carry into hours.
- SET_SS + btn_inc: shadow ss clears to 00.
- btn_mode advances SET_HH→SET_MM→SET_SS→COMMIT.
- btn_mode and btn_inc in the same cycle: mode wins, the increment is discarded.
- COMMIT lasts exactly one cycle:
  - load=1 (registered, asserted in that cycle); load_* carry the shadows.
  - clk_ena=0; a tick in this cycle is dropped.
  - Buttons are ignored. Next state is RUN.
- load_* outputs always reflect the shadows. They are stable whenever load=1.
- Timeout counter (8-bit):
  - Clears on any button pulse and on entry to SET_HH.
  - Increments on tick_1hz in SET states.
  - When it reaches TIMEOUT_S (the tick that makes count==TIMEOUT_S): next state RUN, no load, shadows retained.
  - A button pulse in the same cycle as the expiring tick wins: the counter clears and the press is processed.
- blink toggles on each tick in SET states and clears on return to RUN.
- Reset in any state, including COMMIT: immediate return to reset values, load deasserts asynchronously.
- Shadow arithmetic is BCD only. Captured cur_* values that are not valid BCD are not sanitised, except that an hour of 00 or >12 is forced to 12 on the next hour increment.

Test Plan:
- Reset then RUN: 5 ticks → 5 clk_ena pulses, load=0, mode=0, load_hh=8'h12.
- Capture and hour edit:
  - Stimulus: cur=11:58:30 pm=0; btn_mode, then btn_inc ×2.
  - Response: load_hh goes 11→12 (pm=1)→01; mode=1; clk_ena=0 during ticks.
- Minute wrap and full commit:
  - Stimulus: from SET_MM with mm=58; inc ×2; mode; inc; mode.
  - Response: mm 59→00 with hh unchanged; ss=00.
  - Exactly one load cycle with hh/mm/ss/pm=shadows, then mode=0 and clk_ena follows ticks.
- Simultaneous events:
  - btn_mode+tick in RUN → no clk_ena pulse.
  - btn_mode+btn_inc in SET_HH → mode=2, hh unchanged.
- Timeout with TIMEOUT_S=3: enter SET_HH, 3 ticks → RUN after the 3rd tick, load never asserted. Same again with btn_inc on the 2nd tick → needs 3 more ticks.
- Reset mid-COMMIT: reset asserted in the load cycle → load falls immediately, state RUN, shadows return to 12:00:00.

Source files
------------

// File: rtl/clock_12h_set_ctrl_if.sv
// Signal bundle between the 12-hour time-setting controller and its surroundings:
// tick/button pulses and live time in, counter enable/load and edit display out.
interface clock_12h_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       cur_pm;
    logic       clk_ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       load_pm;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output tick_1hz, btn_mode, btn_inc, cur_hh, cur_mm, cur_ss, cur_pm,
        input  clk_ena, load, load_hh, load_mm, load_ss, load_pm, mode, blink
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, cur_hh, cur_mm, cur_ss, cur_pm,
        output clk_ena, load, load_hh, load_mm, load_ss, load_pm, mode, blink
    );
endinterface

// File: rtl/clock_12h_set_ctrl.sv
// Time-setting controller for a 12-hour BCD clock: freezes the counter while the
// user edits shadow hh/mm/ss/pm, then loads them in a single COMMIT cycle.
module clock_12h_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clock_12h_set_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_HH = 3'd1,
        ST_SET_MM = 3'd2,
        ST_SET_SS = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_S);

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic       load_q;
    logic       blink_q;
    logic [7:0] tmo_q;
    logic [7:0] sh_hh_q;
    logic [7:0] sh_mm_q;
    logic [7:0] sh_ss_q;
    logic       sh_pm_q;

    logic       in_set_s;
    logic       btn_any_s;
    logic [7:0] tmo_inc_s;
    logic       expire_s;
    logic [8:0] hour_next_s;
    logic [7:0] min_next_s;

    // 11->12 flips am/pm; 00 or anything above 12 snaps to 12 without flipping.
    function automatic logic [8:0] hour_step(input logic [7:0] hh, input logic pm);
        logic [8:0] r;
        if ((hh == 8'h00) || (hh > 8'h12)) begin
            r = {pm, 8'h12};
        end else if (hh == 8'h12) begin
            r = {pm, 8'h01};
        end else if (hh == 8'h11) begin
            r = {~pm, 8'h12};
        end else if (hh[3:0] == 4'h9) begin
            r = {pm, hh[7:4] + 4'h1, 4'h0};
        end else begin
            r = {pm, hh[7:4], hh[3:0] + 4'h1};
        end
        return r;
    endfunction

    function automatic logic [7:0] min_step(input logic [7:0] mm);
        logic [7:0] r;
        if (mm == 8'h59) begin
            r = 8'h00;
        end else if (mm[3:0] == 4'h9) begin
            r = {mm[7:4] + 4'h1, 4'h0};
        end else begin
            r = {mm[7:4], mm[3:0] + 4'h1};
        end
        return r;
    endfunction

    function automatic logic [1:0] mode_of(input state_t st);
        logic [1:0] r;
        case (st)
            ST_SET_HH: r = 2'd1;
            ST_SET_MM: r = 2'd2;
            ST_SET_SS: r = 2'd3;
            default:   r = 2'd0;
        endcase
        return r;
    endfunction

    assign in_set_s    = (state_q == ST_SET_HH) || (state_q == ST_SET_MM) || (state_q == ST_SET_SS);
    assign btn_any_s   = bus.btn_mode | bus.btn_inc;
    assign tmo_inc_s   = tmo_q + 8'd1;
    // A button in the expiring cycle takes priority over the timeout.
    assign expire_s    = in_set_s & bus.tick_1hz & ~btn_any_s & (tmo_inc_s == TMO_LIMIT);
    assign hour_next_s = hour_step(sh_hh_q, sh_pm_q);
    assign min_next_s  = min_step(sh_mm_q);

    // Next-state selection for the edit sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.btn_mode) begin
                    state_d = ST_SET_HH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_HH: begin
                if (bus.btn_mode) begin
                    state_d = ST_SET_MM;
                end else if (expire_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SET_HH;
                end
            end
            ST_SET_MM: begin
                if (bus.btn_mode) begin
                    state_d = ST_SET_SS;
                end else if (expire_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SET_MM;
                end
            end
            ST_SET_SS: begin
                if (bus.btn_mode) begin
                    state_d = ST_COMMIT;
                end else if (expire_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SET_SS;
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    assign mode_d = mode_of(state_d);

    // State register with registered mode, load strobe and blink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            mode_q  <= 2'd0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            load_q  <= (state_d == ST_COMMIT);
            if (state_d == ST_RUN) begin
                blink_q <= 1'b0;
            end else if (in_set_s && bus.tick_1hz) begin
                blink_q <= ~blink_q;
            end else begin
                blink_q <= blink_q;
            end
        end
    end

    // Inactivity counter: held at zero outside the edit states so SET_HH starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 8'd0;
        end else if (!in_set_s) begin
            tmo_q <= 8'd0;
        end else if (btn_any_s) begin
            tmo_q <= 8'd0;
        end else if (bus.tick_1hz) begin
            tmo_q <= tmo_inc_s;
        end else begin
            tmo_q <= tmo_q;
        end
    end

    // Shadow time: captured on entry, edited per field, never sanitised beyond hour snapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hh_q <= 8'h12;
            sh_mm_q <= 8'h00;
            sh_ss_q <= 8'h00;
            sh_pm_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.btn_mode) begin
                        sh_hh_q <= bus.cur_hh;
                        sh_mm_q <= bus.cur_mm;
                        sh_ss_q <= bus.cur_ss;
                        sh_pm_q <= bus.cur_pm;
                    end
                end
                ST_SET_HH: begin
                    if (bus.btn_inc && !bus.btn_mode) begin
                        sh_pm_q <= hour_next_s[8];
                        sh_hh_q <= hour_next_s[7:0];
                    end
                end
                ST_SET_MM: begin
                    if (bus.btn_inc && !bus.btn_mode) begin
                        sh_mm_q <= min_next_s;
                    end
                end
                ST_SET_SS: begin
                    if (bus.btn_inc && !bus.btn_mode) begin
                        sh_ss_q <= 8'h00;
                    end
                end
                default: begin
                    sh_hh_q <= sh_hh_q;
                end
            endcase
        end
    end

    // Counter enable is combinational so the tick reaches the counter in its own cycle.
    assign bus.clk_ena = rst_n & bus.tick_1hz & (state_q == ST_RUN) & ~bus.btn_mode;
    assign bus.load    = load_q;
    assign bus.load_hh = sh_hh_q;
    assign bus.load_mm = sh_mm_q;
    assign bus.load_ss = sh_ss_q;
    assign bus.load_pm = sh_pm_q;
    assign bus.mode    = mode_q;
    assign bus.blink   = blink_q;

endmodule

// File: tb/tb_clock_12h_set_ctrl.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a time-of-day model,
// a negedge monitor pops and compares against the controller outputs.
module tb_clock_12h_set_ctrl;

    localparam int TMO = 3;

    typedef struct packed {
        logic       ce;
        logic       ld;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic [1:0] md;
        logic       bl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    clock_12h_set_ctrl_if bus();

    clock_12h_set_ctrl #(.TIMEOUT_S(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   phase = 0;
    bit   mon_on = 1'b0;
    exp_t expq[$];
    int   tagq[$];

    // Model state: st 0=RUN 1=HH 2=MM 3=SS 4=COMMIT; time kept as plain integers.
    int m_st, m_h, m_m, m_s, m_idle;
    bit m_pm, m_bl;
    int c_h, c_m, c_s;
    bit c_pm;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_reset();
        m_st = 0; m_h = 12; m_m = 0; m_s = 0; m_pm = 1'b0; m_bl = 1'b0; m_idle = 0;
    endtask

    task automatic model_step(input bit t, input bit bm, input bit bi);
        bit in_set;
        in_set = (m_st >= 1) && (m_st <= 3);
        if (in_set && t) m_bl = ~m_bl;
        if (m_st == 0) begin
            if (bm) begin
                m_h = from_bcd(to_bcd(c_h)); m_m = c_m; m_s = c_s; m_pm = c_pm;
                m_st = 1; m_idle = 0;
            end
        end else if (m_st == 4) begin
            m_st = 0;
        end else begin
            if (bm) begin
                m_st = m_st + 1;
            end else if (bi) begin
                if (m_st == 1) begin
                    if (m_h == 0 || m_h > 12) m_h = 12;
                    else if (m_h == 11) begin m_h = 12; m_pm = ~m_pm; end
                    else if (m_h == 12) m_h = 1;
                    else m_h = m_h + 1;
                end else if (m_st == 2) begin
                    m_m = (m_m + 1) % 60;
                end else begin
                    m_s = 0;
                end
            end
            if (bm || bi) m_idle = 0;
            else if (t) begin
                m_idle = m_idle + 1;
                if (m_idle == TMO) m_st = 0;
            end
        end
        if (m_st == 0) m_bl = 1'b0;
    endtask

    function automatic exp_t model_out(input bit ce);
        exp_t e;
        e.ce = ce;
        e.ld = (m_st == 4);
        e.hh = to_bcd(m_h);
        e.mm = to_bcd(m_m);
        e.ss = to_bcd(m_s);
        e.pm = m_pm;
        e.md = (m_st == 4) ? 2'd0 : 2'(m_st);
        e.bl = m_bl;
        return e;
    endfunction

    task automatic cyc(input bit t, input bit bm, input bit bi);
        @(posedge clk); #2;
        rst_n = 1'b1;
        bus.tick_1hz = t; bus.btn_mode = bm; bus.btn_inc = bi;
        bus.cur_hh = to_bcd(c_h); bus.cur_mm = to_bcd(c_m);
        bus.cur_ss = to_bcd(c_s); bus.cur_pm = c_pm;
        expq.push_back(model_out(t && (m_st == 0) && !bm));
        tagq.push_back(phase);
        mon_on = 1'b1;
        model_step(t, bm, bi);
    endtask

    task automatic chk(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    // Reset cycle with a tick present to confirm clk_ena stays low under reset.
    task automatic rcyc();
        @(posedge clk); #2;
        if (m_st == 4) chk("load_before_reset", bus.load, 1'b1);
        rst_n = 1'b0;
        bus.tick_1hz = 1'b1; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        model_reset();
        #1;
        chk("load_async_drop", bus.load, 1'b0);
        expq.push_back(model_out(1'b0));
        tagq.push_back(phase);
        mon_on = 1'b1;
    endtask

    exp_t e_mon, g_mon;
    int   t_mon;

    // Monitor: one expectation is due at every falling edge once stimulus has begun.
    always @(negedge clk) begin
        if (mon_on) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: got no expectation, expected one queued");
            end else begin
                e_mon = expq.pop_front();
                t_mon = tagq.pop_front();
                g_mon = {bus.clk_ena, bus.load, bus.load_hh, bus.load_mm, bus.load_ss,
                         bus.load_pm, bus.mode, bus.blink};
                if (g_mon !== e_mon) begin
                    fails++;
                    $display("FAIL outputs phase %0d: got ce=%b ld=%b %h:%h:%h pm=%b md=%0d bl=%b, expected ce=%b ld=%b %h:%h:%h pm=%b md=%0d bl=%b",
                             t_mon, g_mon.ce, g_mon.ld, g_mon.hh, g_mon.mm, g_mon.ss, g_mon.pm,
                             g_mon.md, g_mon.bl, e_mon.ce, e_mon.ld, e_mon.hh, e_mon.mm,
                             e_mon.ss, e_mon.pm, e_mon.md, e_mon.bl);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        bus.cur_hh = 8'h12; bus.cur_mm = 8'h00; bus.cur_ss = 8'h00; bus.cur_pm = 1'b0;
        c_h = 12; c_m = 0; c_s = 0; c_pm = 1'b0;
        model_reset();

        phase = 1;
        repeat (3) rcyc();
        for (int i = 0; i < 5; i++) begin cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); end

        phase = 2;
        c_h = 11; c_m = 58; c_s = 30; c_pm = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);

        phase = 3;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);

        phase = 4;
        c_h = 7; c_m = 9; c_s = 59; c_pm = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        phase = 5;
        repeat (2) rcyc();
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); end

        phase = 6;
        c_h = 4; c_m = 44; c_s = 44; c_pm = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
        rcyc();
        cyc(1'b1, 1'b0, 1'b0);

        phase = 7;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                c_h = $urandom_range(0, 12); c_m = $urandom_range(0, 59);
                c_s = $urandom_range(0, 59); c_pm = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 499) == 0) rcyc();
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 4) == 0);
        end

        @(negedge clk); #1;
        mon_on = 1'b0;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d leftover expectations, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
